// File: rtl/ps2_scan_decoder.sv
// Decodes a PS/2 Set-2 scancode byte stream into make/repeat/break key events.
// Latency: 1 cycle from scan_vld to every output; all outputs are registered.
// Backpressure: none; a byte is consumed every cycle scan_vld is high, and back-to-back bytes are all processed.
//
// Ports:
//   sys_clk, sys_rst         : clock and synchronous active-high reset
//   scan_data, scan_vld      : byte from the PS/2 receiver, with a 1-cycle valid strobe
//   key_code, key_ext        : code and E0 flag of the last non-modifier make or break
//   key_make/repeat/break    : 1-cycle event pulses
//   key_held, key_ascii      : held-key level and its ASCII (0x00 if none or unmapped)
//   shift_held, key_count    : either shift held; count of key_make pulses (wraps)
module ps2_scan_decoder #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [7:0]       scan_data,
  input  logic             scan_vld,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic             key_repeat,
  output logic             key_break,
  output logic             key_held,
  output logic [7:0]       key_ascii,
  output logic             shift_held,
  output logic [CNT_W-1:0] key_count
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             make_q, make_d;
  logic             rep_q, rep_d;
  logic             brk_q, brk_d;
  logic             held_q, held_d;
  logic [7:0]       hcode_q, hcode_d;
  logic             hext_q, hext_d;
  logic             lsh_q, lsh_d;
  logic             rsh_q, rsh_d;
  logic             shift_q, shift_d;
  logic [7:0]       ascii_q, ascii_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic do_make, do_brk, ev_ext, is_ign, is_mod;

  // Set-2 code to ASCII; letters are lowercase unless shift is held.
  function automatic logic [7:0] ascii_map(input logic [7:0] c, input logic e, input logic sh);
    logic [7:0] a;
    logic       letter;
    a      = 8'h00;
    letter = 1'b1;
    if (!e) begin
      case (c)
        8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
        8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
        8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
        8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
        8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
        8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
        8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
        default: letter = 1'b0;
      endcase
      if (letter) begin
        if (sh) a = a - 8'h20;
      end else begin
        case (c)
          8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
          8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
          8'h3E: a = 8'h38;  8'h46: a = 8'h39;  8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
          default: a = 8'h00;
        endcase
      end
    end
    return a;
  endfunction

  always_comb begin
    is_ign = (scan_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF});
  end

  // Prefix FSM: decides whether the current byte is a make or break and whether it is extended.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    do_make = 1'b0;
    do_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (scan_vld) begin
      to_d = '0;
      case (state_q)
        IDLE: begin
          if (scan_data == 8'hE0)      state_d = EXT;
          else if (scan_data == 8'hF0) state_d = BRK;
          else if (!is_ign)            do_make = 1'b1;
        end
        EXT: begin
          if (scan_data == 8'hF0)      state_d = EXT_BRK;
          else if (scan_data == 8'hE0) state_d = EXT;
          else begin
            state_d = IDLE;
            if (!is_ign) begin
              do_make = 1'b1;
              ev_ext  = 1'b1;
            end
          end
        end
        BRK, EXT_BRK: begin
          if (scan_data != 8'hE0 && scan_data != 8'hF0) begin
            state_d = IDLE;
            if (!is_ign) begin
              do_brk = 1'b1;
              ev_ext = (state_q == EXT_BRK);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A stalled prefix is dropped so a lost byte cannot corrupt the next key.
      if (to_q == TO_MAX) begin
        state_d = IDLE;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  // Event handling: modifiers only update shift flags; other keys drive the event outputs.
  always_comb begin
    code_d  = code_q;
    ext_d   = ext_q;
    make_d  = 1'b0;
    rep_d   = 1'b0;
    brk_d   = 1'b0;
    held_d  = held_q;
    hcode_d = hcode_q;
    hext_d  = hext_q;
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    cnt_d   = cnt_q;
    is_mod  = !ev_ext && (scan_data == 8'h12 || scan_data == 8'h59);

    if (do_make) begin
      if (is_mod) begin
        if (scan_data == 8'h12) lsh_d = 1'b1;
        else                    rsh_d = 1'b1;
      end else begin
        code_d = scan_data;
        ext_d  = ev_ext;
        if (held_q && hcode_q == scan_data && hext_q == ev_ext) begin
          rep_d = 1'b1;
        end else begin
          make_d  = 1'b1;
          held_d  = 1'b1;
          hcode_d = scan_data;
          hext_d  = ev_ext;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    end

    if (do_brk) begin
      if (is_mod) begin
        if (scan_data == 8'h12) lsh_d = 1'b0;
        else                    rsh_d = 1'b0;
      end else begin
        brk_d  = 1'b1;
        code_d = scan_data;
        ext_d  = ev_ext;
        if (hcode_q == scan_data && hext_q == ev_ext) held_d = 1'b0;
      end
    end

    shift_d = lsh_d | rsh_d;
    // Computed from next-state values so ASCII tracks shift changes while a key stays held.
    ascii_d = held_d ? ascii_map(hcode_d, hext_d, shift_d) : 8'h00;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      to_q    <= '0;
      code_q  <= '0;
      ext_q   <= 1'b0;
      make_q  <= 1'b0;
      rep_q   <= 1'b0;
      brk_q   <= 1'b0;
      held_q  <= 1'b0;
      hcode_q <= '0;
      hext_q  <= 1'b0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      shift_q <= 1'b0;
      ascii_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      make_q  <= make_d;
      rep_q   <= rep_d;
      brk_q   <= brk_d;
      held_q  <= held_d;
      hcode_q <= hcode_d;
      hext_q  <= hext_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      shift_q <= shift_d;
      ascii_q <= ascii_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_code   = code_q;
  assign key_ext    = ext_q;
  assign key_make   = make_q;
  assign key_repeat = rep_q;
  assign key_break  = brk_q;
  assign key_held   = held_q;
  assign key_ascii  = ascii_q;
  assign shift_held = shift_q;
  assign key_count  = cnt_q;

endmodule
